titan_branch_predictor: RTL and testbench

- Fetch-side branch predictor for the Titan core; the front end of the branch path whose back end is the EX-stage comparator's take_branch decision.
- Predicts direction and target for the fetch PC using a direct-mapped 2-bit saturating-counter table plus a tagged target buffer.
- Trains on branch resolution from EX.
- Flags mispredictions and supplies the corrected PC for the pipeline flush.

---
 rtl/titan_bp_pkg.sv | 8 +
 rtl/titan_branch_predictor_if.sv | 24 ++
 rtl/titan_bp_table.sv | 54 +++++
 rtl/titan_branch_predictor.sv | 57 +++++
 tb/tb_titan_branch_predictor.sv | 228 ++++++++++++++++++++++
 5 files changed

// File: rtl/titan_bp_pkg.sv
// titan_bp_pkg: counter encodings and saturating-counter helper for the branch predictor
package titan_bp_pkg;
  typedef enum logic [1:0] {SNT = 2'b00, WNT = 2'b01, WT = 2'b10, ST = 2'b11} ctr_t;
  localparam ctr_t CTR_RST = WNT;
  function automatic ctr_t ctr_next(ctr_t c, logic taken);
    return taken ? (c == ST ? ST : ctr_t'(c + 2'd1)) : (c == SNT ? SNT : ctr_t'(c - 2'd1));
  endfunction
endpackage

// File: rtl/titan_branch_predictor_if.sv
// titan_branch_predictor_if: fetch prediction and EX resolution signals of the branch predictor
interface titan_branch_predictor_if #(parameter int XLEN = 32);
  logic [XLEN-1:0] fetch_pc_i;
  logic            predict_taken_o;
  logic [XLEN-1:0] predict_target_o;
  logic            resolve_valid_i;
  logic [XLEN-1:0] resolve_pc_i;
  logic            resolve_taken_i;
  logic [XLEN-1:0] resolve_target_i;
  logic            resolve_pred_taken_i;
  logic [XLEN-1:0] resolve_pred_target_i;
  logic            mispredict_o;
  logic [XLEN-1:0] redirect_pc_o;
  modport master (
    output fetch_pc_i, resolve_valid_i, resolve_pc_i, resolve_taken_i, resolve_target_i,
           resolve_pred_taken_i, resolve_pred_target_i,
    input  predict_taken_o, predict_target_o, mispredict_o, redirect_pc_o
  );
  modport slave (
    input  fetch_pc_i, resolve_valid_i, resolve_pc_i, resolve_taken_i, resolve_target_i,
           resolve_pred_taken_i, resolve_pred_target_i,
    output predict_taken_o, predict_target_o, mispredict_o, redirect_pc_o
  );
endinterface

// File: rtl/titan_bp_table.sv
// titan_bp_table: direct-mapped counter/tag/target storage with fetch and resolve read ports
module titan_bp_table
  import titan_bp_pkg::*;
#(
  parameter int ENTRIES = 64,
  parameter int XLEN    = 32,
  localparam int IW     = $clog2(ENTRIES),
  localparam int TW     = XLEN - IW - 2
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic [IW-1:0]   f_idx,
  output ctr_t            f_ctr,
  output logic            f_valid,
  output logic [TW-1:0]   f_tag,
  output logic [XLEN-1:0] f_target,
  input  logic [IW-1:0]   r_idx,
  output ctr_t            r_ctr,
  output logic            r_valid,
  output logic [TW-1:0]   r_tag,
  input  logic            we,
  input  logic            fill,
  input  ctr_t            wr_ctr,
  input  logic [TW-1:0]   wr_tag,
  input  logic [XLEN-1:0] wr_target
);
  ctr_t               ctr    [ENTRIES];
  logic [ENTRIES-1:0] valid;
  logic [TW-1:0]      tag    [ENTRIES];
  logic [XLEN-1:0]    target [ENTRIES];
  assign f_ctr    = ctr[f_idx];
  assign f_valid  = valid[f_idx];
  assign f_tag    = tag[f_idx];
  assign f_target = target[f_idx];
  assign r_ctr    = ctr[r_idx];
  assign r_valid  = valid[r_idx];
  assign r_tag    = tag[r_idx];
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int i = 0; i < ENTRIES; i++) ctr[i] <= CTR_RST;
      valid <= '0;
    end else if (we) begin
      ctr[r_idx]   <= wr_ctr;
      valid[r_idx] <= 1'b1;
    end
  end
  // tags and targets carry no reset; valid gates their use
  always_ff @(posedge clk_i) begin
    if (fill && !rst_i) begin
      tag[r_idx]    <= wr_tag;
      target[r_idx] <= wr_target;
    end
  end
endmodule

// File: rtl/titan_branch_predictor.sv
// titan_branch_predictor: fetch-side direction/target prediction, EX training and mispredict redirect
module titan_branch_predictor
  import titan_bp_pkg::*;
#(
  parameter int ENTRIES = 64,
  parameter int XLEN    = 32
) (
  input logic clk_i,
  input logic rst_i,
  titan_branch_predictor_if.slave bus
);
  localparam int IW = $clog2(ENTRIES);
  localparam int TW = XLEN - IW - 2;
  ctr_t            f_ctr, r_ctr;
  logic            f_valid, r_valid;
  logic [TW-1:0]   f_tag, r_tag;
  logic [XLEN-1:0] f_target;
  logic            f_hit, r_hit, we, fill, mp_cond;
  titan_bp_table #(.ENTRIES(ENTRIES), .XLEN(XLEN)) u_table (
    .clk_i    (clk_i),
    .rst_i    (rst_i),
    .f_idx    (bus.fetch_pc_i[IW+1:2]),
    .f_ctr    (f_ctr),
    .f_valid  (f_valid),
    .f_tag    (f_tag),
    .f_target (f_target),
    .r_idx    (bus.resolve_pc_i[IW+1:2]),
    .r_ctr    (r_ctr),
    .r_valid  (r_valid),
    .r_tag    (r_tag),
    .we       (we),
    .fill     (fill),
    .wr_ctr   (r_hit ? ctr_next(r_ctr, bus.resolve_taken_i) : WT),
    .wr_tag   (bus.resolve_pc_i[XLEN-1:IW+2]),
    .wr_target(bus.resolve_target_i)
  );
  assign f_hit = f_valid && f_tag == bus.fetch_pc_i[XLEN-1:IW+2];
  assign r_hit = r_valid && r_tag == bus.resolve_pc_i[XLEN-1:IW+2];
  assign bus.predict_taken_o  = f_hit && f_ctr[1];
  assign bus.predict_target_o = bus.predict_taken_o ? f_target : bus.fetch_pc_i + XLEN'(4);
  // a not-taken resolve that misses the tag leaves the entry alone
  assign we      = bus.resolve_valid_i && (bus.resolve_taken_i || r_hit);
  assign fill    = bus.resolve_valid_i && bus.resolve_taken_i;
  assign mp_cond = bus.resolve_valid_i &&
                   (bus.resolve_taken_i != bus.resolve_pred_taken_i ||
                    (bus.resolve_taken_i && bus.resolve_target_i != bus.resolve_pred_target_i));
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      bus.mispredict_o  <= 1'b0;
      bus.redirect_pc_o <= '0;
    end else begin
      bus.mispredict_o <= mp_cond;
      if (mp_cond) bus.redirect_pc_o <= bus.resolve_taken_i ? bus.resolve_target_i
                                                            : bus.resolve_pc_i + XLEN'(4);
    end
  end
endmodule

// File: tb/tb_titan_branch_predictor.sv
// tb_titan_branch_predictor: randomized and directed checks against a table-level reference model
module tb_titan_branch_predictor;
  localparam int N = 64;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int errors = 0;
  int checks = 0;
  titan_branch_predictor_if #(.XLEN(32)) bus ();
  titan_branch_predictor #(.ENTRIES(N), .XLEN(32)) dut (.clk_i(clk), .rst_i(rst), .bus(bus));
  always #5 clk = ~clk;

  int          m_ctr   [N];
  bit          m_valid [N];
  int unsigned m_tag   [N];
  logic [31:0] m_tgt   [N];
  bit          exp_mp;
  logic [31:0] exp_rd;

  function automatic int ix(input logic [31:0] pc);
    return int'((pc >> 2) % N);
  endfunction
  function automatic bit m_hit(input logic [31:0] pc);
    return m_valid[ix(pc)] && m_tag[ix(pc)] == int'(pc / (4 * N));
  endfunction
  function automatic bit m_pred(input logic [31:0] pc);
    return m_hit(pc) && m_ctr[ix(pc)] >= 2;
  endfunction
  function automatic logic [31:0] m_ptgt(input logic [31:0] pc);
    return m_pred(pc) ? m_tgt[ix(pc)] : pc + 32'd4;
  endfunction

  task automatic m_reset();
    for (int i = 0; i < N; i++) begin
      m_ctr[i] = 1;
      m_valid[i] = 0;
    end
    exp_mp = 0;
    exp_rd = 0;
  endtask

  task automatic m_update(input logic [31:0] pc, input bit tk, input logic [31:0] tgt);
    int i = ix(pc);
    bit h = m_hit(pc);
    if (tk) begin
      m_ctr[i] = h ? (m_ctr[i] == 3 ? 3 : m_ctr[i] + 1) : 2;
      m_valid[i] = 1;
      m_tag[i] = pc / (4 * N);
      m_tgt[i] = tgt;
    end else if (h) m_ctr[i] = m_ctr[i] == 0 ? 0 : m_ctr[i] - 1;
  endtask

  task automatic drive_resolve(input logic [31:0] pc, input bit tk, input logic [31:0] tgt,
                               input bit ptk, input logic [31:0] ptgt);
    bus.resolve_valid_i = 1;
    bus.resolve_pc_i = pc;
    bus.resolve_taken_i = tk;
    bus.resolve_target_i = tgt;
    bus.resolve_pred_taken_i = ptk;
    bus.resolve_pred_target_i = ptgt;
    exp_mp = (tk != ptk) || (tk && tgt != ptgt);
    if (exp_mp) exp_rd = tk ? tgt : pc + 32'd4;
  endtask

  task automatic clock_resolve();
    @(posedge clk);
    if (rst) m_reset();
    else m_update(bus.resolve_pc_i, bus.resolve_taken_i, bus.resolve_target_i);
    #1;
    bus.resolve_valid_i = 0;
  endtask

  task automatic resolve(input logic [31:0] pc, input bit tk, input logic [31:0] tgt,
                         input bit ptk, input logic [31:0] ptgt);
    drive_resolve(pc, tk, tgt, ptk, ptgt);
    clock_resolve();
  endtask

  task automatic idle();
    @(posedge clk);
    #1;
    exp_mp = 0;
  endtask

  task automatic test_reset();
    rst = 1;
    bus.resolve_valid_i = 0;
    m_reset();
    repeat (2) @(posedge clk);
    #1;
    rst = 0;
    bus.fetch_pc_i = 32'h100;
    #1;
    checks++; if (bus.predict_taken_o !== 1'b0) begin errors++; $display("FAIL reset_pred got=%b exp=0", bus.predict_taken_o); end
    checks++; if (bus.predict_target_o !== 32'h104) begin errors++; $display("FAIL reset_target got=%h exp=00000104", bus.predict_target_o); end
    checks++; if (bus.mispredict_o !== 1'b0) begin errors++; $display("FAIL reset_mp got=%b exp=0", bus.mispredict_o); end
    checks++; if (bus.redirect_pc_o !== 32'h0) begin errors++; $display("FAIL reset_rd got=%h exp=0", bus.redirect_pc_o); end
  endtask

  task automatic test_train();
    for (int k = 0; k < 2; k++) begin
      resolve(32'h100, 1, 32'h80, 0, 32'h0);
      checks++; if (bus.mispredict_o !== 1'b1) begin errors++; $display("FAIL train_mp%0d got=%b exp=1", k, bus.mispredict_o); end
      checks++; if (bus.redirect_pc_o !== 32'h80) begin errors++; $display("FAIL train_rd%0d got=%h exp=00000080", k, bus.redirect_pc_o); end
    end
    idle();
    checks++; if (bus.mispredict_o !== 1'b0) begin errors++; $display("FAIL pulse_once got=%b exp=0", bus.mispredict_o); end
    checks++; if (bus.redirect_pc_o !== 32'h80) begin errors++; $display("FAIL rd_hold got=%h exp=00000080", bus.redirect_pc_o); end
    bus.fetch_pc_i = 32'h100;
    #1;
    checks++; if (bus.predict_taken_o !== 1'b1) begin errors++; $display("FAIL train_pred got=%b exp=1", bus.predict_taken_o); end
    checks++; if (bus.predict_target_o !== 32'h80) begin errors++; $display("FAIL train_target got=%h exp=00000080", bus.predict_target_o); end
  endtask

  task automatic test_saturate();
    repeat (4) resolve(32'h100, 1, 32'h80, 1, 32'h80);
    checks++; if (bus.mispredict_o !== 1'b0) begin errors++; $display("FAIL sat_nomp got=%b exp=0", bus.mispredict_o); end
    resolve(32'h100, 0, 32'h80, 1, 32'h80);
    bus.fetch_pc_i = 32'h100;
    #1;
    checks++; if (bus.predict_taken_o !== 1'b1) begin errors++; $display("FAIL sat_wt_pred got=%b exp=1", bus.predict_taken_o); end
    resolve(32'h100, 0, 32'h80, 1, 32'h80);
    checks++; if (bus.mispredict_o !== 1'b1) begin errors++; $display("FAIL sat_nt_mp got=%b exp=1", bus.mispredict_o); end
    checks++; if (bus.redirect_pc_o !== 32'h104) begin errors++; $display("FAIL sat_nt_rd got=%h exp=00000104", bus.redirect_pc_o); end
    checks++; if (bus.predict_taken_o !== 1'b0) begin errors++; $display("FAIL sat_wnt_pred got=%b exp=0", bus.predict_taken_o); end
  endtask

  task automatic test_alias();
    repeat (2) resolve(32'h100, 1, 32'h80, 0, 32'h0);
    bus.fetch_pc_i = 32'h100 + 4 * N;
    #1;
    checks++; if (bus.predict_taken_o !== 1'b0) begin errors++; $display("FAIL alias_pred got=%b exp=0", bus.predict_taken_o); end
    checks++; if (bus.predict_target_o !== 32'h104 + 4 * N) begin errors++; $display("FAIL alias_target got=%h exp=%h", bus.predict_target_o, 32'h104 + 4 * N); end
  endtask

  task automatic test_target_mismatch();
    resolve(32'h100, 1, 32'h200, 1, 32'h80);
    checks++; if (bus.mispredict_o !== 1'b1) begin errors++; $display("FAIL tgt_mp got=%b exp=1", bus.mispredict_o); end
    checks++; if (bus.redirect_pc_o !== 32'h200) begin errors++; $display("FAIL tgt_rd got=%h exp=00000200", bus.redirect_pc_o); end
    bus.fetch_pc_i = 32'h100;
    #1;
    checks++; if (bus.predict_target_o !== 32'h200) begin errors++; $display("FAIL tgt_update got=%h exp=00000200", bus.predict_target_o); end
  endtask

  task automatic test_wrap();
    resolve(32'hFFFF_FFFC, 0, 32'h40, 1, 32'h40);
    checks++; if (bus.redirect_pc_o !== 32'h0) begin errors++; $display("FAIL wrap_rd got=%h exp=0", bus.redirect_pc_o); end
    bus.fetch_pc_i = 32'hFFFF_FFFC;
    #1;
    checks++; if (bus.predict_target_o !== 32'h0) begin errors++; $display("FAIL wrap_target got=%h exp=0", bus.predict_target_o); end
  endtask

  task automatic test_same_cycle();
    repeat (3) resolve(32'h100, 0, 32'h200, 0, 32'h0);
    resolve(32'h100, 1, 32'h200, 1, 32'h200);
    bus.fetch_pc_i = 32'h100;
    drive_resolve(32'h100, 1, 32'h200, 0, 32'h0);
    #1;
    checks++; if (bus.predict_taken_o !== 1'b0) begin errors++; $display("FAIL same_old got=%b exp=0", bus.predict_taken_o); end
    clock_resolve();
    checks++; if (bus.predict_taken_o !== m_pred(32'h100)) begin errors++; $display("FAIL same_new got=%b exp=%b", bus.predict_taken_o, m_pred(32'h100)); end
  endtask

  task automatic test_reset_mid();
    repeat (3) resolve(32'h100, 1, 32'h200, 1, 32'h200);
    drive_resolve(32'h100, 1, 32'h300, 0, 32'h0);
    rst = 1;
    clock_resolve();
    rst = 0;
    checks++; if (bus.mispredict_o !== 1'b0) begin errors++; $display("FAIL rstmid_mp got=%b exp=0", bus.mispredict_o); end
    checks++; if (bus.redirect_pc_o !== 32'h0) begin errors++; $display("FAIL rstmid_rd got=%h exp=0", bus.redirect_pc_o); end
    bus.fetch_pc_i = 32'h100;
    #1;
    checks++; if (bus.predict_taken_o !== 1'b0) begin errors++; $display("FAIL rstmid_pred got=%b exp=0", bus.predict_taken_o); end
    repeat (1) resolve(32'h100, 1, 32'h300, 0, 32'h0);
    checks++; if (bus.predict_taken_o !== 1'b1) begin errors++; $display("FAIL rstmid_wt got=%b exp=1", bus.predict_taken_o); end
  endtask

  task automatic test_random();
    logic [31:0] pcs [6] = '{32'h100, 32'h104, 32'h100 + 4 * N, 32'h1100, 32'h3C, 32'hFFFF_FFFC};
    for (int k = 0; k < 300; k++) begin
      logic [31:0] rpc, fpc, tgt, ptgt;
      bit tk, ptk, exp_pt;
      logic [31:0] exp_pg;
      rpc = pcs[$urandom_range(0, 5)];
      fpc = pcs[$urandom_range(0, 5)];
      tk = 1'($urandom_range(0, 1));
      tgt = {$urandom_range(0, 7), 4'h0};
      ptk = $urandom_range(0, 3) == 0 ? ~m_pred(rpc) : m_pred(rpc);
      ptgt = $urandom_range(0, 3) == 0 ? tgt : m_ptgt(rpc);
      exp_pt = m_pred(fpc);
      exp_pg = m_ptgt(fpc);
      bus.fetch_pc_i = fpc;
      if ($urandom_range(0, 4) != 0) drive_resolve(rpc, tk, tgt, ptk, ptgt);
      else begin
        bus.resolve_valid_i = 0;
        exp_mp = 0;
      end
      #1;
      checks++; if (bus.predict_taken_o !== exp_pt || bus.predict_target_o !== exp_pg) begin errors++; $display("FAIL rnd_pred%0d pc=%h got=%b/%h exp=%b/%h", k, fpc, bus.predict_taken_o, bus.predict_target_o, exp_pt, exp_pg); end
      if (bus.resolve_valid_i) clock_resolve();
      else idle();
      checks++; if (bus.mispredict_o !== exp_mp || bus.redirect_pc_o !== exp_rd) begin errors++; $display("FAIL rnd_mp%0d got=%b/%h exp=%b/%h", k, bus.mispredict_o, bus.redirect_pc_o, exp_mp, exp_rd); end
    end
  endtask

  initial begin
    bus.fetch_pc_i = 0;
    bus.resolve_valid_i = 0;
    bus.resolve_pc_i = 0;
    bus.resolve_taken_i = 0;
    bus.resolve_target_i = 0;
    bus.resolve_pred_taken_i = 0;
    bus.resolve_pred_target_i = 0;
    test_reset();
    test_train();
    test_saturate();
    test_reset();
    test_alias();
    test_target_mismatch();
    test_wrap();
    test_same_cycle();
    test_reset_mid();
    test_reset();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
